hwpe_ctrl_ucode_sequencer: RTL and testbench
============================================

Name: hwpe_ctrl_ucode_sequencer

Overview:
- Sits on the controller side of the microcode loop engine and consumes its flags.
- Drives the engine's enable and clear inputs and captures each iteration's offsets, loop indices and accumulation flag into a small FIFO.
- Presents the captured entries to the streamers as a valid/ready command stream.
- Provides backpressure, so the engine never advances further than the streamers can absorb.

Parameters:
- NB_REG, 4, number of offset registers exported by the engine
- REG_WIDTH, 32, width of each offset register
- NB_LOOPS, 6, number of loop index counters
- CNT_WIDTH, 12, width of each loop index
- FIFO_DEPTH, 4, command FIFO entries; must be at least 2
- CMD_CNT_WIDTH, 16, width of the issued-command counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- start_i  in  1  job start pulse; only honoured in IDLE
- ucode_enable_o  out  1  step enable to the engine
- ucode_clear_o  out  1  clear to the engine
- ucode_valid_i  in  1  engine iteration-complete pulse
- ucode_done_i  in  1  engine done flag
- ucode_accum_i  in  1  engine accumulation flag
- ucode_offs_i  in  NB_REG*REG_WIDTH  engine offset registers, packed
- ucode_idx_i  in  NB_LOOPS*CNT_WIDTH  engine loop indices, packed
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  command ready
- cmd_offs_o  out  NB_REG*REG_WIDTH  command offsets
- cmd_idx_o  out  NB_LOOPS*CNT_WIDTH  command loop indices
- cmd_accum_o  out  1  command accumulation flag
- cmd_last_o  out  1  final command of the job
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle end-of-job pulse
- overflow_o  out  1  sticky: a push was attempted into a full FIFO
- nb_cmd_o  out  CMD_CNT_WIDTH  commands handshaken since the last start

Behaviour:
- Reset: every register clears. FSM goes to IDLE, FIFO empties, nb_cmd_o=0, overflow_o=0. All outputs are 0.
- States:
  - IDLE -> START on start_i.
  - START (one cycle) -> RUN.
  - RUN -> DRAIN on a push with ucode_done_i=1.
  - DRAIN -> FINISH when the FIFO is empty.
  - FINISH (one cycle) -> IDLE.
- ucode_clear_o = clear_i OR (state==START). It is combinational and lasts exactly one cycle per start.
- In START, nb_cmd_o and overflow_o are cleared.
- ucode_enable_o = (state==RUN) AND (fifo_count <= FIFO_DEPTH-2). Keeping at least 2 free slots covers the engine's one-cycle valid latency after enable drops.
- Push occurs when ucode_valid_i=1 in state RUN. The entry is {offs, idx, accum, last=ucode_done_i}.
- ucode_valid_i outside RUN is ignored.
- Push into a full FIFO: the entry is dropped and overflow_o is set to 1 (sticky until START, clear_i or reset).
- FIFO and handshake:
  - First-word fall-through. cmd_* reflect the head entry.
  - cmd_valid_o = not empty.
  - Pop on cmd_valid_o AND cmd_ready_i.
  - A simultaneous push and pop when full succeeds, with no overflow.
- Head stability: cmd_* stay stable while cmd_valid_o=1 and cmd_ready_i=0.
- nb_cmd_o increments on each handshake and saturates at all-ones.
- done_o = (state==FINISH).
- busy_o = (state!=IDLE).
- start_i outside IDLE is ignored, and produces no ucode_clear_o.
- clear_i at any state, same cycle: FIFO flushed, next state IDLE, ucode_clear_o=1, no done_o. nb_cmd_o and overflow_o are retained.
- clear_i has priority over start_i and over a simultaneous push.
- Pointer arithmetic wraps modulo FIFO_DEPTH, and the count is kept explicitly (width $clog2(FIFO_DEPTH+1)).
- Reset asserted mid-job: immediate return to the reset state, with no done_o.

Test Plan:
- Basic job: start_i. Engine model yields 3 valids, the third with done=1, and cmd_ready_i tied 1. Required: ucode_clear_o pulses once; 3 commands in order with cmd_last_o only on the third; done_o one cycle after the FIFO empties; nb_cmd_o=3.
- Backpressure: FIFO_DEPTH=4, cmd_ready_i=0. Required: ucode_enable_o drops when fifo_count reaches 3. The engine's last in-flight valid fills entry 4 with overflow_o=0. Raising ready resumes enable once count<=2.
- Forced overflow: the engine model pushes a valid with the FIFO full and ready=0. Required: overflow_o=1, entry dropped, FIFO contents unchanged. The next start_i clears overflow_o.
- Hold stability: randomized ready over a 20-command job with random offs/idx. Required: cmd_* never change while valid&&!ready; the scoreboard matches all 20; nb_cmd_o=20.
- Clear mid-job: clear_i during RUN with 2 entries queued. Required: same-cycle ucode_clear_o=1, next cycle cmd_valid_o=0 and busy_o=0, no done_o. A subsequent start_i runs cleanly.
- Ignored start: start_i pulsed during RUN and during DRAIN. Required: no ucode_clear_o, no state change, and the job completes with the correct command count.

Source files
------------

// File: rtl/hwpe_ctrl_ucode_sequencer.sv
// Controller-side sequencer for the microcode loop engine: steps the engine,
// queues each iteration's offsets/indices and serves them as a valid/ready command stream.
module hwpe_ctrl_ucode_sequencer #(
  parameter int unsigned NB_REG        = 4,
  parameter int unsigned REG_WIDTH     = 32,
  parameter int unsigned NB_LOOPS      = 6,
  parameter int unsigned CNT_WIDTH     = 12,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CMD_CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  output logic                          ucode_enable_o,
  output logic                          ucode_clear_o,
  input  logic                          ucode_valid_i,
  input  logic                          ucode_done_i,
  input  logic                          ucode_accum_i,
  input  logic [NB_REG*REG_WIDTH-1:0]   ucode_offs_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0] ucode_idx_i,
  output logic                          cmd_valid_o,
  input  logic                          cmd_ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]   cmd_offs_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0] cmd_idx_o,
  output logic                          cmd_accum_o,
  output logic                          cmd_last_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o,
  output logic [CMD_CNT_WIDTH-1:0]      nb_cmd_o
);

  localparam int unsigned OFFS_W = NB_REG * REG_WIDTH;
  localparam int unsigned IDX_W  = NB_LOOPS * CNT_WIDTH;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);
  localparam logic [FCNT_W-1:0] FCNT_ENA  = FCNT_W'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [OFFS_W-1:0] r_offs  [FIFO_DEPTH];
  logic [IDX_W-1:0]  r_idx   [FIFO_DEPTH];
  logic              r_accum [FIFO_DEPTH];
  logic              r_last  [FIFO_DEPTH];

  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [FCNT_W-1:0]        r_count;
  logic                     r_overflow;
  logic [CMD_CNT_WIDTH-1:0] r_nb_cmd;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_push;
  logic w_hs;
  logic w_ovf;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FCNT_FULL);
  assign w_push_req = ucode_valid_i && (r_state == S_RUN) && !clear_i;
  assign w_hs       = !w_empty && cmd_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_hs);
  assign w_ovf      = w_push_req && w_full && !w_hs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start_i) w_state_nxt = S_START;
        S_START:  w_state_nxt = S_RUN;
        S_RUN:    if (w_push_req && ucode_done_i) w_state_nxt = S_DRAIN;
        S_DRAIN:  if (w_empty) w_state_nxt = S_FINISH;
        S_FINISH: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ucode_clear_o  = clear_i || (r_state == S_START);
    // Two free slots absorb the valid the engine still emits after enable drops.
    ucode_enable_o = (r_state == S_RUN) && (r_count <= FCNT_ENA);
    busy_o         = (r_state != S_IDLE);
    done_o         = (r_state == S_FINISH) && !clear_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_hs)   r_rptr <= next_ptr(r_rptr);
      if (w_push && !w_hs)      r_count <= r_count + 1'b1;
      else if (!w_push && w_hs) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_offs[i]  <= '0;
        r_idx[i]   <= '0;
        r_accum[i] <= 1'b0;
        r_last[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_offs[r_wptr]  <= ucode_offs_i;
      r_idx[r_wptr]   <= ucode_idx_i;
      r_accum[r_wptr] <= ucode_accum_i;
      r_last[r_wptr]  <= ucode_done_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
      r_nb_cmd   <= '0;
    end else if (r_state == S_START) begin
      r_overflow <= 1'b0;
      r_nb_cmd   <= '0;
    end else begin
      if (w_ovf) r_overflow <= 1'b1;
      if (w_hs && (r_nb_cmd != '1)) r_nb_cmd <= r_nb_cmd + 1'b1;
    end
  end

  assign cmd_valid_o = !w_empty;
  assign cmd_offs_o  = r_offs[r_rptr];
  assign cmd_idx_o   = r_idx[r_rptr];
  assign cmd_accum_o = r_accum[r_rptr];
  assign cmd_last_o  = r_last[r_rptr];
  assign overflow_o  = r_overflow;
  assign nb_cmd_o    = r_nb_cmd;

endmodule

// File: tb/tb_hwpe_ctrl_ucode_sequencer.sv
// Directed bench for hwpe_ctrl_ucode_sequencer with a one-cycle-latency engine model.
`timescale 1ns/1ps
module tb_hwpe_ctrl_ucode_sequencer;

  localparam int NB_REG = 4, REG_WIDTH = 32, NB_LOOPS = 6, CNT_WIDTH = 12;
  localparam int FIFO_DEPTH = 4, CMD_CNT_WIDTH = 16;
  localparam int OW = NB_REG * REG_WIDTH;
  localparam int IW = NB_LOOPS * CNT_WIDTH;

  typedef struct packed {
    logic [OW-1:0] offs;
    logic [IW-1:0] idx;
    logic          accum;
    logic          last;
  } cmd_t;

  logic clk_i = 1'b0;
  logic rst_ni, clear_i, start_i;
  logic ucode_valid_i, ucode_done_i, ucode_accum_i, cmd_ready_i;
  logic [OW-1:0] ucode_offs_i;
  logic [IW-1:0] ucode_idx_i;
  logic ucode_enable_o, ucode_clear_o, cmd_valid_o, cmd_accum_o, cmd_last_o;
  logic busy_o, done_o, overflow_o;
  logic [OW-1:0] cmd_offs_o;
  logic [IW-1:0] cmd_idx_o;
  logic [CMD_CNT_WIDTH-1:0] nb_cmd_o;

  hwpe_ctrl_ucode_sequencer #(
    .NB_REG(NB_REG), .REG_WIDTH(REG_WIDTH), .NB_LOOPS(NB_LOOPS), .CNT_WIDTH(CNT_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH), .CMD_CNT_WIDTH(CMD_CNT_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .ucode_enable_o(ucode_enable_o), .ucode_clear_o(ucode_clear_o),
    .ucode_valid_i(ucode_valid_i), .ucode_done_i(ucode_done_i), .ucode_accum_i(ucode_accum_i),
    .ucode_offs_i(ucode_offs_i), .ucode_idx_i(ucode_idx_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_offs_o(cmd_offs_o), .cmd_idx_o(cmd_idx_o), .cmd_accum_o(cmd_accum_o),
    .cmd_last_o(cmd_last_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o), .nb_cmd_o(nb_cmd_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0, failures = 0;
  cmd_t exp_q[$], obs_q[$];
  int   eng_n = 0, eng_issued = 0;
  logic eng_pend = 1'b0;
  bit   eng_manual = 1'b0;
  bit   ready_rand = 1'b0;
  logic ready_val = 1'b0;
  int   cyc = 0, clear_cnt = 0, done_cnt = 0, hold_err = 0, last_hs_cyc = 0, done_cyc = 0;
  logic prev_stall = 1'b0;
  cmd_t prev_head;

  // One clock: drive engine/ready after the edge, observe at the falling edge.
  task automatic step();
    cmd_t e, head;
    logic [95:0] t;
    if (ready_rand) cmd_ready_i = ($urandom_range(0, 1) == 1);
    else            cmd_ready_i = ready_val;
    if (!eng_manual) begin
      if (eng_pend) begin
        t       = {$urandom, $urandom, $urandom};
        e.offs  = {$urandom, $urandom, $urandom, $urandom};
        e.idx   = t[IW-1:0];
        e.accum = t[95];
        e.last  = (eng_issued == eng_n - 1);
        exp_q.push_back(e);
        eng_issued++;
        ucode_valid_i = 1'b1; ucode_offs_i = e.offs; ucode_idx_i = e.idx;
        ucode_accum_i = e.accum; ucode_done_i = e.last;
      end else begin
        ucode_valid_i = 1'b0; ucode_done_i = 1'b0;
      end
    end
    @(negedge clk_i);
    cyc++;
    head = {cmd_offs_o, cmd_idx_o, cmd_accum_o, cmd_last_o};
    if (prev_stall && (!cmd_valid_o || head !== prev_head)) hold_err++;
    prev_stall = cmd_valid_o && !cmd_ready_i && !clear_i;
    prev_head  = head;
    if (cmd_valid_o && cmd_ready_i) begin obs_q.push_back(head); last_hs_cyc = cyc; end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (ucode_clear_o) begin clear_cnt++; eng_issued = 0; eng_pend = 1'b0; end
    else eng_pend = ucode_enable_o && (eng_issued < eng_n);
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; step(); start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
  endtask

  function automatic cmd_t mk(input logic [31:0] k, input logic last);
    cmd_t e;
    e.offs  = {32'hA000_0000 + k, 32'hB000_0000 + k, 32'hC000_0000 + k, 32'hD000_0000 + k};
    e.idx   = {6{k[11:0] + 12'h011}};
    e.accum = k[0];
    e.last  = last;
    return e;
  endfunction

  task automatic manual_push(input cmd_t e);
    ucode_valid_i = 1'b1; ucode_offs_i = e.offs; ucode_idx_i = e.idx;
    ucode_accum_i = e.accum; ucode_done_i = e.last;
    step();
    ucode_valid_i = 1'b0; ucode_done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; ucode_valid_i = 1'b0; ucode_done_i = 1'b0;
    ucode_accum_i = 1'b0; ucode_offs_i = '0; ucode_idx_i = '0; cmd_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid got=%b exp=0", cmd_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow_o); end
    checks++; if (nb_cmd_o !== '0) begin failures++; $display("FAIL rst_nb_cmd got=%0d exp=0", nb_cmd_o); end
    checks++; if (ucode_enable_o !== 1'b0) begin failures++; $display("FAIL rst_enable got=%b exp=0", ucode_enable_o); end
    checks++; if (ucode_clear_o !== 1'b0) begin failures++; $display("FAIL rst_uclear got=%b exp=0", ucode_clear_o); end
    checks++; if (cmd_offs_o !== '0) begin failures++; $display("FAIL rst_offs got=%h exp=0", cmd_offs_o); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok; int c0, d0;
    exp_q.delete(); obs_q.delete();
    eng_manual = 0; eng_n = 3; ready_rand = 0; ready_val = 1'b1;
    c0 = clear_cnt; d0 = done_cnt;
    pulse_start();
    run_until_done(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (clear_cnt - c0 != 1) begin failures++; $display("FAIL basic_uclear_pulses got=%0d exp=1", clear_cnt - c0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
    checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL basic_ncmd got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL basic_cmd%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (obs_q.size() == 3 && {obs_q[0].last, obs_q[1].last, obs_q[2].last} !== 3'b001) begin
      failures++; $display("FAIL basic_last got=%b%b%b exp=001", obs_q[0].last, obs_q[1].last, obs_q[2].last);
    end
    checks++; if (done_cyc - last_hs_cyc != 2) begin failures++; $display("FAIL basic_done_latency got=%0d exp=2", done_cyc - last_hs_cyc); end
    checks++; if (nb_cmd_o !== 16'd3) begin failures++; $display("FAIL basic_nb_cmd got=%0d exp=3", nb_cmd_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy_o); end
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_q.delete(); obs_q.delete();
    eng_manual = 0; eng_n = 8; ready_rand = 0; ready_val = 1'b0;
    pulse_start();
    repeat (10) step();
    checks++; if (ucode_enable_o !== 1'b0) begin failures++; $display("FAIL bp_enable_full got=%b exp=0", ucode_enable_o); end
    checks++; if (exp_q.size() != 4) begin failures++; $display("FAIL bp_issued got=%0d exp=4", exp_q.size()); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL bp_overflow got=%b exp=0", overflow_o); end
    checks++; if (cmd_valid_o !== 1'b1 || {cmd_offs_o, cmd_idx_o, cmd_accum_o, cmd_last_o} !== exp_q[0]) begin
      failures++; $display("FAIL bp_head got=%b/%h exp=1/%h", cmd_valid_o, {cmd_offs_o, cmd_idx_o, cmd_accum_o, cmd_last_o}, exp_q[0]);
    end
    ready_val = 1'b1; step(); ready_val = 1'b0;
    checks++; if (ucode_enable_o !== 1'b0) begin failures++; $display("FAIL bp_enable_cnt3 got=%b exp=0", ucode_enable_o); end
    ready_val = 1'b1; step();
    checks++; if (ucode_enable_o !== 1'b1) begin failures++; $display("FAIL bp_enable_cnt2 got=%b exp=1", ucode_enable_o); end
    run_until_done(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL bp_ncmd got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL bp_cmd%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (nb_cmd_o !== 16'd8) begin failures++; $display("FAIL bp_nb_cmd got=%0d exp=8", nb_cmd_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL bp_overflow_end got=%b exp=0", overflow_o); end
  endtask

  task automatic test_overflow();
    bit ok;
    obs_q.delete();
    eng_manual = 1; eng_n = 0; ready_rand = 0; ready_val = 1'b0;
    ucode_valid_i = 1'b0; ucode_done_i = 1'b0;
    pulse_start();
    step();
    for (int i = 0; i < 4; i++) manual_push(mk(i, 1'b0));
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", overflow_o); end
    manual_push(mk(32'h55, 1'b0));
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
    checks++; if ({cmd_offs_o, cmd_idx_o, cmd_accum_o, cmd_last_o} !== mk(0, 1'b0)) begin
      failures++; $display("FAIL ovf_head got=%h exp=%h", {cmd_offs_o, cmd_idx_o, cmd_accum_o, cmd_last_o}, mk(0, 1'b0));
    end
    ready_val = 1'b1;
    repeat (5) step();
    checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL ovf_ncmd got=%0d exp=4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== mk(i, 1'b0)) begin
        failures++; $display("FAIL ovf_cmd%0d got=%h exp=%h", i, obs_q[i], mk(i, 1'b0));
      end
    end
    manual_push(mk(32'h77, 1'b1));
    run_until_done(20, ok);
    checks++; if (!ok || obs_q.size() != 5 || obs_q[4] !== mk(32'h77, 1'b1)) begin
      failures++; $display("FAIL ovf_final got=ok%0d/n%0d exp=ok1/n5", ok, obs_q.size());
    end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    pulse_start();
    step();
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_start_clr got=%b exp=0", overflow_o); end
    checks++; if (nb_cmd_o !== '0) begin failures++; $display("FAIL ovf_start_nb got=%0d exp=0", nb_cmd_o); end
    clear_i = 1'b1; step(); clear_i = 1'b0;
    eng_manual = 0;
  endtask

  task automatic test_hold();
    bit ok;
    exp_q.delete(); obs_q.delete();
    eng_manual = 0; eng_n = 20; ready_rand = 1;
    hold_err = 0; prev_stall = 1'b0;
    pulse_start();
    run_until_done(400, ok);
    ready_rand = 0;
    checks++; if (!ok) begin failures++; $display("FAIL hold_timeout got=no_done exp=done"); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL hold_stable got=%0d exp=0", hold_err); end
    checks++; if (obs_q.size() != 20) begin failures++; $display("FAIL hold_ncmd got=%0d exp=20", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL hold_cmd%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (nb_cmd_o !== 16'd20) begin failures++; $display("FAIL hold_nb_cmd got=%0d exp=20", nb_cmd_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL hold_overflow got=%b exp=0", overflow_o); end
  endtask

  task automatic test_clear_mid_job();
    bit ok; int d0;
    obs_q.delete();
    eng_manual = 1; ready_rand = 0; ready_val = 1'b0;
    pulse_start();
    step();
    for (int i = 0; i < 3; i++) manual_push(mk(32'h20 + i, 1'b0));
    ready_val = 1'b1; step(); ready_val = 1'b0;
    d0 = done_cnt;
    clear_i = 1'b1;
    ucode_valid_i = 1'b1; ucode_offs_i = mk(32'h99, 1'b0).offs; ucode_done_i = 1'b0;
    #1;
    checks++; if (ucode_clear_o !== 1'b1) begin failures++; $display("FAIL clr_uclear got=%b exp=1", ucode_clear_o); end
    checks++; if (cmd_valid_o !== 1'b1) begin failures++; $display("FAIL clr_pre_valid got=%b exp=1", cmd_valid_o); end
    step();
    clear_i = 1'b0; ucode_valid_i = 1'b0;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", cmd_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy_o); end
    checks++; if (nb_cmd_o !== 16'd1) begin failures++; $display("FAIL clr_nb_kept got=%0d exp=1", nb_cmd_o); end
    repeat (3) step();
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL clr_no_done got=%0d exp=%0d", done_cnt, d0); end
    exp_q.delete(); obs_q.delete();
    eng_manual = 0; eng_n = 3; ready_val = 1'b1;
    pulse_start();
    run_until_done(50, ok);
    checks++; if (!ok || obs_q.size() != 3) begin failures++; $display("FAIL clr_rerun got=ok%0d/n%0d exp=ok1/n3", ok, obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL clr_cmd%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (nb_cmd_o !== 16'd3) begin failures++; $display("FAIL clr_rerun_nb got=%0d exp=3", nb_cmd_o); end
  endtask

  task automatic test_ignored_start();
    bit ok; int c0, d0;
    exp_q.delete(); obs_q.delete();
    eng_manual = 0; eng_n = 3; ready_rand = 0; ready_val = 1'b0;
    c0 = clear_cnt; d0 = done_cnt;
    pulse_start();
    step();
    start_i = 1'b1; #1;
    checks++; if (ucode_clear_o !== 1'b0) begin failures++; $display("FAIL ign_run_uclear got=%b exp=0", ucode_clear_o); end
    step(); start_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ign_run_busy got=%b exp=1", busy_o); end
    repeat (6) step();
    checks++; if (cmd_valid_o !== 1'b1 || exp_q.size() != 3) begin
      failures++; $display("FAIL ign_drain_fill got=%b/%0d exp=1/3", cmd_valid_o, exp_q.size());
    end
    start_i = 1'b1; #1;
    checks++; if (ucode_clear_o !== 1'b0) begin failures++; $display("FAIL ign_drain_uclear got=%b exp=0", ucode_clear_o); end
    step(); start_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || cmd_valid_o !== 1'b1) begin
      failures++; $display("FAIL ign_drain_state got=%b%b exp=11", busy_o, cmd_valid_o);
    end
    ready_val = 1'b1;
    run_until_done(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ign_timeout got=no_done exp=done"); end
    checks++; if (clear_cnt - c0 != 1) begin failures++; $display("FAIL ign_uclear_pulses got=%0d exp=1", clear_cnt - c0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ign_done_pulses got=%0d exp=1", done_cnt - d0); end
    checks++; if (nb_cmd_o !== 16'd3) begin failures++; $display("FAIL ign_nb_cmd got=%0d exp=3", nb_cmd_o); end
  endtask

  task automatic test_reset_mid_job();
    int d0;
    exp_q.delete(); obs_q.delete();
    eng_manual = 0; eng_n = 5; ready_val = 1'b0;
    pulse_start();
    repeat (4) step();
    d0 = done_cnt;
    rst_ni = 1'b0; #1;
    checks++; if (busy_o !== 1'b0 || cmd_valid_o !== 1'b0 || done_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%b%b%b exp=000", busy_o, cmd_valid_o, done_o);
    end
    eng_n = 0;
    step();
    rst_ni = 1'b1;
    repeat (3) step();
    checks++; if (done_cnt != d0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_quiet got=done%0d/busy%b exp=done%0d/busy0", done_cnt, busy_o, d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_hold();
    test_clear_mid_job();
    test_ignored_start();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
